// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-size codes, FSM state
// encoding and the default register width/address width.
package wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data aligner: picks the addressed byte/half out of the
// raw memory word and sign- or zero-extends it to DATA_W.
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        size,
    input  logic              ld_signed,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase

        // Halfword loads only look at addr_lo[1]; a misaligned bit 0 is ignored.
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            LD_BYTE: data = {{(DATA_W-8){ld_signed & byte_v[7]}}, byte_v};
            LD_HALF: data = {{(DATA_W-16){ld_signed & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: retires ALU results and aligned load data into the register
// file as a one-cycle wren pulse. Define WB_FWD_EN to add WRITE-stage forwarding.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_regwrite,
    input  logic              in_is_load,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_signed,
    input  logic [1:0]        in_addr_lo,
    input  logic [DATA_W-1:0] in_alu,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0] fwd_rs1,
    input  logic [ADDR_W-1:0] fwd_rs2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddr,
    output logic [DATA_W-1:0] wrdata
);

    wb_state_t         state;
    wb_state_t         state_n;

    logic [ADDR_W-1:0] pend_rd;
    logic [1:0]        pend_size;
    logic              pend_signed;
    logic [1:0]        pend_lo;

    logic              capture;
    logic              latch;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    logic [1:0]        al_size;
    logic              al_signed;
    logic [1:0]        al_lo;
    logic [DATA_W-1:0] aligned;

    // One aligner serves both the immediate-load path and the waiting-load path.
    assign al_size   = (state == WAIT_LOAD) ? pend_size   : in_ld_size;
    assign al_signed = (state == WAIT_LOAD) ? pend_signed : in_ld_signed;
    assign al_lo     = (state == WAIT_LOAD) ? pend_lo     : in_addr_lo;

    load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .size     (al_size),
        .ld_signed(al_signed),
        .addr_lo  (al_lo),
        .rdata    (mem_rdata),
        .data     (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wraddr      <= '0;
            wrdata      <= '0;
            pend_rd     <= '0;
            pend_size   <= LD_WORD;
            pend_signed <= 1'b0;
            pend_lo     <= 2'd0;
        end else begin
            state <= state_n;
            if (capture) begin
                wraddr <= cap_addr;
                wrdata <= cap_data;
            end
            if (latch) begin
                pend_rd     <= in_rd;
                pend_size   <= in_ld_size;
                pend_signed <= in_ld_signed;
                pend_lo     <= in_addr_lo;
            end
        end
    end

    // WRITE accepts like IDLE so back-to-back retirements never bubble;
    // rd=0 and non-writing instructions are swallowed without a pulse.
    always_comb begin
        state_n  = state;
        in_ready = 1'b1;
        wren     = 1'b0;
        capture  = 1'b0;
        latch    = 1'b0;
        cap_addr = in_rd;
        cap_data = in_alu;
        case (state)
            WAIT_LOAD: begin
                in_ready = 1'b0;
                cap_addr = pend_rd;
                cap_data = aligned;
                if (mem_rvalid) begin
                    capture = 1'b1;
                    state_n = WRITE;
                end
            end
            default: begin
                wren    = (state == WRITE);
                state_n = IDLE;
                if (in_valid && in_regwrite && (in_rd != '0)) begin
                    if (!in_is_load) begin
                        capture = 1'b1;
                        state_n = WRITE;
                    end else if (mem_rvalid) begin
                        capture  = 1'b1;
                        cap_data = aligned;
                        state_n  = WRITE;
                    end else begin
                        latch   = 1'b1;
                        state_n = WAIT_LOAD;
                    end
                end
            end
        endcase
    end

`ifdef WB_FWD_EN
    always_comb begin
        fwd_hit1  = (state == WRITE) && (wraddr != '0) && (fwd_rs1 == wraddr);
        fwd_hit2  = (state == WRITE) && (wraddr != '0) && (fwd_rs2 == wraddr);
        fwd_data1 = fwd_hit1 ? wrdata : '0;
        fwd_data2 = fwd_hit2 ? wrdata : '0;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vectors, a behavioural writeback model
// checked every cycle, and literal expectations for the key scenarios.
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wren;
    logic [4:0]  wraddr;
    logic [31:0] wrdata;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1;
    logic [4:0]  fwd_rs2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    int checks   = 0;
    int failures = 0;

    regfile_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .in_is_load  (in_is_load),
        .in_ld_size  (in_ld_size),
        .in_ld_signed(in_ld_signed),
        .in_addr_lo  (in_addr_lo),
        .in_alu      (in_alu),
`ifdef WB_FWD_EN
        .fwd_rs1     (fwd_rs1),
        .fwd_rs2     (fwd_rs2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2),
`endif
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wren        (wren),
        .wraddr      (wraddr),
        .wrdata      (wrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result computed arithmetically: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] modelAlign(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] v;
        int          bits;
        if (size == 2'd0) begin
            v    = (rd >> (8 * lo)) & 32'h0000_00FF;
            bits = 8;
        end else if (size == 2'd1) begin
            v    = (rd >> (16 * lo[1])) & 32'h0000_FFFF;
            bits = 16;
        end else begin
            v    = rd;
            bits = 32;
        end
        if (sgn && bits < 32 && v[bits-1])
            v = v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    logic        m_wait;
    logic [4:0]  m_rd;
    logic [1:0]  m_size;
    logic        m_sgn;
    logic [1:0]  m_lo;
    logic        m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait <= 1'b0;
            m_wren <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
        end else begin
            m_wren <= 1'b0;
            if (m_wait) begin
                if (mem_rvalid) begin
                    m_wren <= 1'b1;
                    m_addr <= m_rd;
                    m_data <= modelAlign(m_size, m_sgn, m_lo, mem_rdata);
                    m_wait <= 1'b0;
                end
            end else if (in_valid && in_regwrite && in_rd != 5'd0) begin
                if (!in_is_load) begin
                    m_wren <= 1'b1;
                    m_addr <= in_rd;
                    m_data <= in_alu;
                end else if (mem_rvalid) begin
                    m_wren <= 1'b1;
                    m_addr <= in_rd;
                    m_data <= modelAlign(in_ld_size, in_ld_signed, in_addr_lo, mem_rdata);
                end else begin
                    m_wait <= 1'b1;
                    m_rd   <= in_rd;
                    m_size <= in_ld_size;
                    m_sgn  <= in_ld_signed;
                    m_lo   <= in_addr_lo;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("model_in_ready", {31'd0, in_ready}, {31'd0, !m_wait});
        checkOutput("model_wren", {31'd0, wren}, {31'd0, m_wren});
        if (rst || m_wren) begin
            checkOutput("model_wraddr", {27'd0, wraddr}, {27'd0, m_addr});
            checkOutput("model_wrdata", wrdata, m_data);
        end
        if (wren)
            checkOutput("wren_addr_nonzero", {31'd0, wraddr != 5'd0}, 32'd1);
`ifdef WB_FWD_EN
        checkOutput("model_fwd_hit1", {31'd0, fwd_hit1},
                    {31'd0, m_wren && m_addr != 5'd0 && fwd_rs1 == m_addr});
        checkOutput("model_fwd_hit2", {31'd0, fwd_hit2},
                    {31'd0, m_wren && m_addr != 5'd0 && fwd_rs2 == m_addr});
        checkOutput("model_fwd_data1", fwd_data1,
                    (m_wren && m_addr != 5'd0 && fwd_rs1 == m_addr) ? m_data : 32'd0);
        checkOutput("model_fwd_data2", fwd_data2,
                    (m_wren && m_addr != 5'd0 && fwd_rs2 == m_addr) ? m_data : 32'd0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic rw,
                                 input logic ld, input logic [1:0] sz, input logic sg,
                                 input logic [1:0] lo, input logic [31:0] alu,
                                 input logic rv, input logic [31:0] rdat);
        in_valid     = v;
        in_rd        = rd;
        in_regwrite  = rw;
        in_is_load   = ld;
        in_ld_size   = sz;
        in_ld_signed = sg;
        in_addr_lo   = lo;
        in_alu       = alu;
        mem_rvalid   = rv;
        mem_rdata    = rdat;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads[8];

    initial begin
        loads[0] = '{2'd0, 1'b0, 2'd0, 32'h12F4_5678, 32'h0000_0078};
        loads[1] = '{2'd0, 1'b1, 2'd1, 32'h12F4_5678, 32'h0000_0056};
        loads[2] = '{2'd0, 1'b1, 2'd3, 32'h92F4_5678, 32'hFFFF_FF92};
        loads[3] = '{2'd1, 1'b0, 2'd2, 32'h8001_0000, 32'h0000_8001};
        loads[4] = '{2'd1, 1'b1, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
        loads[5] = '{2'd1, 1'b1, 2'd3, 32'h8001_0000, 32'hFFFF_8001};
        loads[6] = '{2'd1, 1'b1, 2'd0, 32'h1234_ABCD, 32'hFFFF_ABCD};
        loads[7] = '{2'd2, 1'b1, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        rst = 1'b1;
        idle();
`ifdef WB_FWD_EN
        fwd_rs1 = 5'd0;
        fwd_rs2 = 5'd0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_wren", {31'd0, wren}, 32'd0);
        checkOutput("rst_wraddr", {27'd0, wraddr}, 32'd0);
        checkOutput("rst_wrdata", wrdata, 32'd0);
        step();
        rst = 1'b0;

        // ALU write to r3, with a stray rvalid during WRITE that must be ignored
        step();
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_00AB, 1'b0, 32'd0);
        step();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("alu_wren", {31'd0, wren}, 32'd1);
        checkOutput("alu_wraddr", {27'd0, wraddr}, 32'd3);
        checkOutput("alu_wrdata", wrdata, 32'h0000_00AB);
        step();
        idle();
        @(negedge clk);
        checkOutput("alu_wren_after", {31'd0, wren}, 32'd0);

        // signed byte load, read data arrives on the third waiting cycle
        step();
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b1, 2'd0, 1'b1, 2'd2, 32'd0, 1'b0, 32'd0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ldwait_in_ready", {31'd0, in_ready}, 32'd0);
            if (i == 2) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h12F4_5678;
            end
            step();
        end
        idle();
        @(negedge clk);
        checkOutput("ldwait_wren", {31'd0, wren}, 32'd1);
        checkOutput("ldwait_wraddr", {27'd0, wraddr}, 32'd6);
        checkOutput("ldwait_wrdata", wrdata, 32'hFFFF_FFF4);

        // immediate loads across sizes, lanes and extension modes
        for (int k = 0; k < 8; k++) begin
            step();
            applyStimulus(1'b1, 5'd7, 1'b1, 1'b1, loads[k].size, loads[k].sgn, loads[k].lo,
                          32'h5A5A_5A5A, 1'b1, loads[k].rdata);
            step();
            idle();
            @(negedge clk);
            checkOutput($sformatf("load%0d_wrdata", k), wrdata, loads[k].exp);
        end

        // back-to-back ALU stream of four
        for (int i = 0; i < 4; i++) begin
            step();
            applyStimulus(1'b1, 5'(i + 1), 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h100 + i, 1'b0, 32'd0);
            if (i > 0) begin
                @(negedge clk);
                checkOutput("b2b_wren", {31'd0, wren}, 32'd1);
                checkOutput("b2b_wraddr", {27'd0, wraddr}, i);
            end
        end
        step();
        idle();
        @(negedge clk);
        checkOutput("b2b_wren_last", {31'd0, wren}, 32'd1);
        checkOutput("b2b_wrdata_last", wrdata, 32'h0000_0103);

        // dropped instructions: rd=0, regwrite=0, load to r0
        step();
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h1111_1111, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("drop_wren_b2b_tail", {31'd0, wren}, 32'd0);
        step();
        applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h2222_2222, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("drop_rd0_wren", {31'd0, wren}, 32'd0);
        step();
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("drop_regwrite0_wren", {31'd0, wren}, 32'd0);
        step();
        idle();
        @(negedge clk);
        checkOutput("drop_load_r0_wren", {31'd0, wren}, 32'd0);
        checkOutput("drop_load_r0_ready", {31'd0, in_ready}, 32'd1);

        // reset while waiting for load data abandons the write
        step();
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd0, 1'b0, 32'd0);
        step();
        idle();
        @(negedge clk);
        checkOutput("rstwait_ready_before", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #2;
        checkOutput("rstwait_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rstwait_wren", {31'd0, wren}, 32'd0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        idle();
        @(negedge clk);
        checkOutput("rstwait_late_rvalid_wren", {31'd0, wren}, 32'd0);
        step();
        @(negedge clk);
        checkOutput("rstwait_late_rvalid_wren2", {31'd0, wren}, 32'd0);

`ifdef WB_FWD_EN
        step();
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_0055, 1'b0, 32'd0);
        fwd_rs1 = 5'd5;
        fwd_rs2 = 5'd0;
        step();
        idle();
        @(negedge clk);
        checkOutput("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
        checkOutput("fwd_data1", fwd_data1, 32'h0000_0055);
        checkOutput("fwd_hit2", {31'd0, fwd_hit2}, 32'd0);
        checkOutput("fwd_data2", fwd_data2, 32'd0);
        step();
        @(negedge clk);
        checkOutput("fwd_hit1_after", {31'd0, fwd_hit1}, 32'd0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
